// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the 1011 sequence generator and detectors.
//   seq_state_e : generator FSM states (IDLE, SEND, GAP)
//   SEQ_1011    : the reference pattern, sent/checked MSB first
// ---------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

  localparam logic [3:0] SEQ_1011 = 4'b1011;

endpackage : seq_pkg

// File: rtl/seq_1011_gen.sv
// ---------------------------------------------------------------------------
// seq_1011_gen
// Serial pattern generator. On start it emits PATTERN (MSB first) `reps`
// times with `gap` idle zeros between repetitions, and marks the last bit of
// every pattern with match_exp so a detector's output can be checked.
//
// Ports
//   clk       in   single clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   run request, sampled only while idle
//   abort     in   synchronous stop, back to idle without done
//   reps      in   number of pattern repetitions (latched at start)
//   gap       in   zero bits between repetitions (latched at start)
//   x         out  serial stream bit
//   x_valid   out  x carries a pattern or gap bit this cycle
//   match_exp out  high on the last bit of each pattern
//   busy      out  high while sending pattern or gap bits
//   done      out  one-cycle pulse after normal completion
// All outputs are registered.
// ---------------------------------------------------------------------------
module seq_1011_gen
  import seq_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_1011),
  parameter int unsigned      CNT_W   = 8,
  parameter int unsigned      GAP_W   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             match_exp,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  seq_state_e       state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [CNT_W-1:0] rep_q,     rep_d;      // repetitions still to send, incl. current
  logic [GAP_W-1:0] gap_len_q, gap_len_d;  // latched gap length
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;  // gap bits still to send, incl. current

  logic x_q,     x_d;
  logic valid_q, valid_d;
  logic match_q, match_d;
  logic busy_q,  busy_d;
  logic done_q,  done_d;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. state_q describes the bit being driven in the current
  // cycle; the outputs for the next cycle are decoded from the next state so
  // that every output leaves a flop.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (reps != '0) begin
            rep_d     = reps;
            gap_len_d = gap;
            idx_d     = IDX_LAST;
            state_d   = SEND;
          end else begin
            // Zero repetitions: nothing to send, complete immediately.
            done_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (idx_q == '0) begin
          rep_d = rep_q - CNT_W'(1);
          if (rep_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (gap_len_q == '0) begin
            idx_d = IDX_LAST;             // back-to-back pattern
          end else begin
            gap_cnt_d = gap_len_q;
            state_d   = GAP;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          gap_cnt_d = '0;
          idx_d     = IDX_LAST;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d   = IDLE;
      idx_d     = '0;
      rep_d     = '0;
      gap_len_d = '0;
      gap_cnt_d = '0;
      done_d    = 1'b0;
    end

    // Registered output decode from the next state.
    x_d     = (state_d == SEND) ? PATTERN[idx_d] : 1'b0;
    valid_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
    match_d = (state_d == SEND) && (idx_d == '0);
  end

  assign x         = x_q;
  assign x_valid   = valid_q;
  assign match_exp = match_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule : seq_1011_gen
